// File: rtl/core_ctrl_pkg.sv
// Shared constants for the multi-cycle core control path: state encoding,
// opcode values and the default memory acknowledge timeout.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int DEFAULT_ACK_TIMEOUT = 255;
  localparam int WAIT_W              = 8;

endpackage

// File: rtl/ack_timeout_counter.sv
// Wait-cycle counter for memory handshakes; flags the cycle that would be the
// limit-th consecutive cycle without an acknowledge. A zero limit never expires.
module ack_timeout_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (limit != '0) && (count >= (limit - 1'b1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory and write-back
// sequencing with retire counting and memory-timeout halt.
//
//   state  | meaning
//   RESET  | outputs idle, leaves on first clock after reset
//   FETCH  | instruction request until imem_ack
//   DECODE | one cycle, system opcode halts
//   EXEC   | one cycle, retires ALU/branch ops without write-back
//   MEM    | data request until dmem_ack
//   WB     | register-file write and retire
//   HALT   | absorbing until reset
module multicycle_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        is_branch,
  input  logic        is_jump,
  input  logic        is_system,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        reg_write_from_load,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_write_en,
  output logic        wb_from_load,
  output logic        pc_write,
  output logic        pc_sel,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic        halted,
  output logic        timeout_err
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(ACK_TIMEOUT);

  state_t state_q;
  logic   exec_retire;
  logic   waiting;
  logic   acked;
  logic   wait_clear;
  logic   expired;

  assign state = state_q;

  assign waiting    = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign acked      = ((state_q == ST_FETCH) && imem_ack) || ((state_q == ST_MEM) && dmem_ack);
  assign wait_clear = !waiting || acked;

  ack_timeout_counter #(.W(WAIT_W)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .enable  (!wait_clear),
    .limit   (LIMIT),
    .expired (expired)
  );

  // Strobes decode from the held state plus the stable decoded controls, so
  // the retire pulse lands in the last cycle of each instruction.
  always_comb begin
    exec_retire  = (state_q == ST_EXEC) && !mem_read && !mem_write && !reg_write;
    imem_req     = (state_q == ST_FETCH);
    ir_load      = (state_q == ST_FETCH) && imem_ack;
    dmem_req     = (state_q == ST_MEM);
    dmem_we      = (state_q == ST_MEM) && mem_write;
    rf_write_en  = (state_q == ST_WB);
    wb_from_load = (state_q == ST_WB) && reg_write_from_load;
    pc_write     = exec_retire || (state_q == ST_WB) ||
                   ((state_q == ST_MEM) && dmem_ack && !mem_read);
    pc_sel       = 1'b0;
    if (exec_retire) begin
      pc_sel = (is_branch && branch_taken) || is_jump;
    end else if (state_q == ST_WB) begin
      pc_sel = is_jump;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RESET;
      instret     <= '0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (pc_write) begin
        instret <= instret + 32'd1;
      end
      case (state_q)
        ST_RESET:  state_q <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ack) begin
            state_q <= ST_DECODE;
          end else if (expired) begin
            state_q     <= ST_HALT;
            halted      <= 1'b1;
            timeout_err <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (is_system) begin
            state_q <= ST_HALT;
            halted  <= 1'b1;
          end else begin
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (mem_read || mem_write) begin
            state_q <= ST_MEM;
          end else if (reg_write) begin
            state_q <= ST_WB;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            state_q <= mem_read ? ST_WB : ST_FETCH;
          end else if (expired) begin
            state_q     <= ST_HALT;
            halted      <= 1'b1;
            timeout_err <= 1'b1;
          end
        end
        ST_WB:     state_q <= ST_FETCH;
        ST_HALT:   state_q <= ST_HALT;
        default:   state_q <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: expected retire records are
// queued as each instruction is driven and popped on every pc_write pulse.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ack, dmem_ack;
  logic        is_branch, is_jump, is_system;
  logic        mem_read, mem_write, reg_write, reg_write_from_load, branch_taken;
  logic        imem_req, ir_load, dmem_req, dmem_we, rf_write_en, wb_from_load;
  logic        pc_write, pc_sel;
  logic [2:0]  state;
  logic [31:0] instret;
  logic        halted, timeout_err;

  multicycle_sequencer #(.ACK_TIMEOUT(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .imem_ack            (imem_ack),
    .dmem_ack            (dmem_ack),
    .is_branch           (is_branch),
    .is_jump             (is_jump),
    .is_system           (is_system),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .reg_write           (reg_write),
    .reg_write_from_load (reg_write_from_load),
    .branch_taken        (branch_taken),
    .imem_req            (imem_req),
    .ir_load             (ir_load),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .rf_write_en         (rf_write_en),
    .wb_from_load        (wb_from_load),
    .pc_write            (pc_write),
    .pc_sel              (pc_sel),
    .state               (state),
    .instret             (instret),
    .halted              (halted),
    .timeout_err         (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {imem_req, ir_load, dmem_req, dmem_we, rf_write_en, wb_from_load, pc_write, pc_sel};
  endfunction

  typedef struct {
    int          lat;
    logic        sel;
    logic        rf;
    logic        wfl;
    int          dreq;
    logic        dwe;
    logic [31:0] ib;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [2:0]  slog[$];
  logic [31:0] model_instret;
  int          cyc, dreq_cnt;
  logic        rf_seen, wfl_seen, dwe_seen;
  logic [2:0]  prev_state;

  // Retire monitor: measures latency from FETCH entry and what happened on the way.
  always @(negedge clk) begin
    if (!rst) begin
      prev_state = 3'd0;
      cyc        = 0;
    end else begin
      slog.push_back(state);
      if (state == 3'd1 && prev_state != 3'd1) begin
        cyc = 0; rf_seen = 0; wfl_seen = 0; dwe_seen = 0; dreq_cnt = 0;
      end
      cyc++;
      if (rf_write_en)  rf_seen  = 1'b1;
      if (wb_from_load) wfl_seen = 1'b1;
      if (dmem_we)      dwe_seen = 1'b1;
      if (dmem_req)     dreq_cnt++;
      if (pc_write) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("latency",     cyc,      mon_e.lat);
          chk("pc_sel",      pc_sel,   mon_e.sel);
          chk("rf_write_en", rf_seen,  mon_e.rf);
          chk("wb_from_ld",  wfl_seen, mon_e.wfl);
          chk("dmem_req_n",  dreq_cnt, mon_e.dreq);
          chk("dmem_we",     dwe_seen, mon_e.dwe);
          chk("instret_pre", instret,  mon_e.ib);
        end
      end
      prev_state = state;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n = 0;
    while (state !== s && n < 60) begin
      tick();
      n++;
    end
    chk(tag, state, s);
  endtask

  task automatic run_instr(input logic br, input logic tk, input logic jmp,
                           input logic mr, input logic mw, input logic rw,
                           input logic rwl, input int iwait, input int dwait);
    exp_t e;
    logic mem, wb;
    is_branch = br; branch_taken = tk; is_jump = jmp; is_system = 1'b0;
    mem_read = mr; mem_write = mw; reg_write = rw; reg_write_from_load = rwl;
    wait_state(3'd1, "w_fetch");
    mem    = mr || mw;
    wb     = mem ? mr : rw;
    e.lat  = 3 + iwait + (mem ? 1 + dwait : 0) + (wb ? 1 : 0);
    e.sel  = mem ? (wb ? jmp : 1'b0) : (wb ? jmp : ((br && tk) || jmp));
    e.rf   = wb;
    e.wfl  = wb && rwl;
    e.dreq = mem ? dwait + 1 : 0;
    e.dwe  = mem && mw;
    e.ib   = model_instret;
    model_instret = model_instret + 32'd1;
    sb.push_back(e);
    repeat (iwait) tick();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    if (mem) begin
      wait_state(3'd4, "w_mem");
      repeat (dwait) tick();
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
    end
    wait_state(3'd1, "w_refetch");
  endtask

  task automatic clear_inputs();
    imem_ack = 0; dmem_ack = 0; is_branch = 0; is_jump = 0; is_system = 0;
    mem_read = 0; mem_write = 0; reg_write = 0; reg_write_from_load = 0; branch_taken = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  exp_seq[5];
    logic [31:0] i0;
    exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    clear_inputs();
    model_instret = 32'd0;
    #2 rst = 1'b0;
    tick(); tick();
    chk("rst_state",   state,       3'd0);
    chk("rst_instret", instret,     32'd0);
    chk("rst_halted",  halted,      1'b0);
    chk("rst_terr",    timeout_err, 1'b0);
    chk("rst_strobes", strobes(),   8'd0);

    // Register add with zero-wait acks, tracing the state walk.
    slog.delete();
    rst = 1'b1;
    run_instr(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("seq_len", slog.size(), 5);
    for (int i = 0; i < 5 && i < slog.size(); i++) chk($sformatf("seq%0d", i), slog[i], exp_seq[i]);
    chk("seq_end", state, 3'd1);
    chk("add_instret", instret, 32'd1);

    run_instr(0, 0, 0, 1, 0, 1, 1, 0, 3);   // load, dmem_ack on 4th MEM cycle
    run_instr(1, 1, 0, 0, 0, 0, 0, 0, 0);   // taken branch
    run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0);   // not-taken branch
    run_instr(0, 0, 0, 0, 1, 0, 0, 1, 1);   // store with waits
    run_instr(0, 0, 1, 0, 0, 1, 0, 0, 0);   // jal with link write
    run_instr(0, 0, 0, 0, 0, 1, 0, 3, 0);   // imem_ack exactly at the limit
    chk("limit_no_err", timeout_err, 1'b0);
    chk("instret_7", instret, 32'd7);

    // Wrap: preload the counter while idle in FETCH.
    force dut.instret = 32'hFFFF_FFFF;
    #1 release dut.instret;
    model_instret = 32'hFFFF_FFFF;
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap", instret, 32'd0);

    // Fetch timeout with ACK_TIMEOUT=4.
    i0 = instret;
    repeat (3) tick();
    chk("to_still_fetch", state, 3'd1);
    chk("to_no_irload", ir_load, 1'b0);
    tick();
    chk("to_state",   state,       3'd6);
    chk("to_err",     timeout_err, 1'b1);
    chk("to_halted",  halted,      1'b1);
    chk("to_instret", instret,     i0);
    chk("to_strobes", strobes(),   8'd0);

    rst = 1'b0; tick(); rst = 1'b1;
    model_instret = 32'd0;

    // System opcode halts from DECODE; later acks ignored.
    is_system = 1'b1;
    wait_state(3'd1, "w_sys_fetch");
    imem_ack = 1'b1;
    #1 chk("sys_irload", ir_load, 1'b1);
    tick();
    imem_ack = 1'b0;
    chk("sys_decode", state, 3'd2);
    tick();
    chk("sys_halt",   state,       3'd6);
    chk("sys_halted", halted,      1'b1);
    chk("sys_noerr",  timeout_err, 1'b0);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("halt_hold%0d", i), {state, strobes()}, {3'd6, 8'd0});
    end
    clear_inputs();
    rst = 1'b0;
    #1 chk("rst_async_halt", {state, halted, strobes()}, {3'd0, 1'b0, 8'd0});
    tick(); rst = 1'b1;

    // Reset asserted during a MEM wait.
    run_instr(0, 0, 0, 0, 0, 1, 0, 0, 0);
    mem_read = 1; reg_write = 1; reg_write_from_load = 1;
    wait_state(3'd1, "w_m_fetch");
    imem_ack = 1'b1; tick(); imem_ack = 1'b0;
    wait_state(3'd4, "w_m_mem");
    tick(); tick();
    chk("mw_req", dmem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mw_rst_strobes", strobes(), 8'd0);
    chk("mw_rst_state",   state,     3'd0);
    chk("mw_rst_instret", instret,   32'd0);
    dmem_ack = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("mw_restart", state, 3'd1);
    chk("mw_no_pcw", pc_write, 1'b0);
    clear_inputs();
    model_instret = 32'd0;
    run_instr(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("mw_after", instret, 32'd1);

    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
